cp0_ext: RTL
============

# cp0_ext

Parametrised coprocessor-0 for the pipelined MIPS core. It adds a configurable number of external interrupt lines, a Count/Compare timer interrupt and a BadVAddr register, and defines interrupt-versus-exception priority. It sits beside the M stage. It samples the victim instruction's PC, delay-slot flag and exception code, raises `int_req` to redirect fetch to the handler, and serves `mfc0`/`mtc0`/`eret`.

## Interface
- `N_HWINT`, 5: number of external interrupt lines, legal range 1..5. They map to IP/IM bits [10 +: N_HWINT].
- `TIMER_EN`, 1: 1 enables Count increment and the timer interrupt on IP/IM bit 15. 0 holds Count and keeps `timer_irq` at 0.
- `PRID`, 32'h0000_0808: reset value of PRId.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `we` in 1: `mtc0` write enable.
- `rd_addr` in 5: read register number.
- `wr_addr` in 5: write register number.
- `wdata` in 32: write data.
- `rdata` out 32: combinational read data.
- `pc` in 32: PC of the M-stage instruction.
- `bd_in` in 1: the M-stage instruction is in a delay slot.
- `exc_code` in 5: synchronous exception code. 0 means none.
- `bad_vaddr` in 32: faulting address, used when `exc_code` is 4 or 5.
- `hw_int` in N_HWINT: level-sensitive device interrupts.
- `eret` in 1: clears EXL.
- `int_req` out 1: take exception or interrupt this cycle.
- `epc` out 32: current EPC, for `eret` redirect.
- `timer_irq` out 1: timer pending bit.

## Operation
- Register map:
  - 8 BadVAddr, read-only.
  - 9 Count, read/write.
  - 11 Compare, read/write.
  - 12 SR = {16'b0, IM[15:10], 8'b0, EXL, IE}.
  - 13 Cause = {BD, 15'b0, IP[15:10], 3'b0, ExcCode, 2'b0}, read-only.
  - 14 EPC, read/write, bits [1:0] forced to 0.
  - 15 PRId, read-only.
  - Any other address reads 0. Writes to read-only or unmapped addresses are ignored.
- Pending vector: `pend` = {ti, 0-pad, hw_int}, 6 bits.
  - Cause.IP is a registered copy of `pend`, updated every cycle.
  - IP bits not backed by a line read 0.
- Request logic:
  - IntReq = |(pend & IM) & IE & !EXL, using live `pend`.
  - ExcReq = (`exc_code` != 0) & !EXL.
  - `int_req` = (IntReq | ExcReq) & !reset.
- On an edge with `int_req`=1:
  - EXL <= 1.
  - BD <= `bd_in`.
  - EPC <= {pc[31:2], 2'b00} - (`bd_in` ? 4 : 0).
  - ExcCode <= IntReq ? 0 : `exc_code`. Interrupts have priority over a simultaneous exception.
  - BadVAddr <= `bad_vaddr`, only if ExcReq & !IntReq & `exc_code` is 4 or 5.
  - Any `mtc0` in the same cycle is discarded.
- `eret` with `int_req`=0: EXL <= 0 and BD <= 0. If `eret` and `int_req` coincide, `int_req` wins.
- Timer:
  - Count increments by 1 every cycle and wraps 0xFFFF_FFFF -> 0.
  - A write to Count loads `wdata` and suppresses that cycle's increment.
  - ti <= 1 on an edge where the current Count == Compare.
  - ti is sticky, and is cleared only by a write to Compare. The clear wins over a same-cycle set.
  - `timer_irq` = ti.
- A write to EPC has lower priority than the exception update of EPC.

## Timing
- Reset values:
  - SR = 0, Cause = 0, EPC = 0, Count = 0, BadVAddr = 0.
  - Compare = 32'hFFFF_FFFF, ti = 0, PRId = `PRID`.
  - `int_req` = 0, `timer_irq` = 0, `rdata` = value of the addressed register.
- Asserting `reset` mid-operation clears all state immediately (asynchronously), including a pending EXL.
- `int_req` is combinational in the same cycle as its cause. EPC, EXL, Cause and BadVAddr change at that edge and are visible the next cycle.
- `mtc0` effects are visible on `rdata` the cycle after the write edge. A write to SR that enables IE with pending lines raises `int_req` in the next cycle.
- The timer interrupt is visible in Cause.IP[15] and `int_req` one cycle after ti sets, that is two edges after Count == Compare.
- While EXL=1, no new `int_req` is issued, whatever the `hw_int` or `exc_code` inputs.

## Test plan
- Reset: assert `reset` asynchronously mid-cycle, read regs 12/13/14/9/11/15 -> 0, 0, 0, 0, 0xFFFFFFFF, `PRID`; `int_req`=0.
- External interrupt: SR=0x0000_0401, `hw_int`[0]=1, pc=0x3010, `bd_in`=0 -> `int_req`=1 that cycle; next cycle EPC=0x3010, Cause=0x0000_0400, SR=0x0000_0403.
- Delay slot plus exception: `exc_code`=4, `bad_vaddr`=0x1003, pc=0x3024, `bd_in`=1, IE=0 -> EPC=0x3020, Cause=0x8000_0010, BadVAddr=0x1003.
- Priority: `hw_int`[1]=1 (IM set, IE=1) together with `exc_code`=10 -> Cause.ExcCode=0, BadVAddr unchanged, same-cycle `mtc0` to EPC discarded.
- Timer: write Count=0, then Compare=3 with IM[15]=1, IE=1 -> `timer_irq` rises after the edge where Count=3, `int_req` follows one cycle later; writing Compare=100 clears `timer_irq` next cycle.
- Handler nesting and `eret`: with EXL=1, pulse `hw_int` and `exc_code`=12 -> `int_req` stays 0; `eret` -> EXL=0, BD=0, the still-pending `hw_int` raises `int_req` the following cycle.

Source files
------------

// File: rtl/cp0_ext.sv
// cp0_ext: MIPS coprocessor-0 extension beside the M stage.
// Provides external interrupt lines, a Count/Compare timer interrupt,
// BadVAddr capture, interrupt-over-exception priority, mfc0/mtc0/eret.
//
// Ports:
//   clk, reset        rising-edge clock, asynchronous active-high reset
//   we, wr_addr, wdata mtc0 write port
//   rd_addr, rdata    mfc0 read port (rdata is combinational)
//   pc, bd_in         M-stage PC and delay-slot flag of the victim instruction
//   exc_code          synchronous exception code (0 = none)
//   bad_vaddr         faulting address, captured for exc_code 4/5
//   hw_int            level-sensitive device interrupt lines
//   eret              return from handler (clears EXL and BD)
//   int_req           combinational: take exception/interrupt this cycle
//   epc               current EPC for eret redirect
//   timer_irq         timer pending bit
module cp0_ext #(
    parameter int unsigned N_HWINT  = 5,
    parameter bit          TIMER_EN = 1'b1,
    parameter logic [31:0] PRID     = 32'h0000_0808
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                we,
    input  logic [4:0]          rd_addr,
    input  logic [4:0]          wr_addr,
    input  logic [31:0]         wdata,
    output logic [31:0]         rdata,
    input  logic [31:0]         pc,
    input  logic                bd_in,
    input  logic [4:0]          exc_code,
    input  logic [31:0]         bad_vaddr,
    input  logic [N_HWINT-1:0]  hw_int,
    input  logic                eret,
    output logic                int_req,
    output logic [31:0]         epc,
    output logic                timer_irq
);

    localparam int unsigned XLEN  = 32;
    localparam int unsigned IP_W  = 6;
    localparam int unsigned EXC_W = 5;

    localparam logic [4:0] ADDR_BADVADDR = 5'd8;
    localparam logic [4:0] ADDR_COUNT    = 5'd9;
    localparam logic [4:0] ADDR_COMPARE  = 5'd11;
    localparam logic [4:0] ADDR_SR       = 5'd12;
    localparam logic [4:0] ADDR_CAUSE    = 5'd13;
    localparam logic [4:0] ADDR_EPC      = 5'd14;
    localparam logic [4:0] ADDR_PRID     = 5'd15;

    localparam logic [XLEN-1:0] WORD_MASK = 32'hFFFF_FFFC;

    logic [XLEN-1:0]  r_count;
    logic [XLEN-1:0]  r_compare;
    logic             r_ti;
    logic [IP_W-1:0]  r_ip;
    logic [IP_W-1:0]  r_im;
    logic             r_ie;
    logic             r_exl;
    logic             r_bd;
    logic [EXC_W-1:0] r_exc;
    logic [XLEN-1:0]  r_epc;
    logic [XLEN-1:0]  r_badvaddr;

    logic [IP_W-1:0]  w_pend;
    logic [IP_W-1:0]  w_pend_req;
    logic             w_int_req;
    logic             w_exc_req;
    logic             w_take;
    logic             w_wr;
    logic             w_badv_cap;
    logic [XLEN-1:0]  w_epc_exc;

    // Live pending vector: {ti, zero pad, hw_int}
    always_comb begin
        w_pend                = '0;
        w_pend[N_HWINT-1:0]   = hw_int;
        w_pend[IP_W-1]        = r_ti;
    end

    // Timer contributes to the request through its registered IP copy, so the
    // request trails timer_irq by one cycle; device lines act immediately.
    always_comb begin
        w_pend_req           = w_pend;
        w_pend_req[IP_W-1]   = r_ip[IP_W-1];
    end

    // Request and write-qualification logic
    always_comb begin
        w_int_req  = (|(w_pend_req & r_im)) & r_ie & ~r_exl;
        w_exc_req  = (exc_code != EXC_W'(0)) & ~r_exl;
        w_take     = (w_int_req | w_exc_req) & ~reset;
        w_wr       = we & ~w_take;
        w_badv_cap = w_exc_req & ~w_int_req &
                     ((exc_code == EXC_W'(4)) | (exc_code == EXC_W'(5)));
        w_epc_exc  = (pc & WORD_MASK) - (bd_in ? XLEN'(4) : XLEN'(0));
    end

    assign int_req   = w_take;
    assign epc       = r_epc;
    assign timer_irq = r_ti;

    // Count: mtc0 load suppresses the increment
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (w_wr && (wr_addr == ADDR_COUNT)) begin
            r_count <= wdata;
        end else if (TIMER_EN) begin
            r_count <= r_count + XLEN'(1);
        end
    end

    // Compare and sticky timer pending; Compare write clear beats a match
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_compare <= 32'hFFFF_FFFF;
            r_ti      <= 1'b0;
        end else if (w_wr && (wr_addr == ADDR_COMPARE)) begin
            r_compare <= wdata;
            r_ti      <= 1'b0;
        end else if (TIMER_EN && (r_count == r_compare)) begin
            r_ti      <= 1'b1;
        end
    end

    // Cause.IP snapshot of the live pending vector
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ip <= '0;
        end else begin
            r_ip <= w_pend;
        end
    end

    // Exception entry, SR/EPC writes and eret; entry overrides any mtc0
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_im       <= '0;
            r_ie       <= 1'b0;
            r_exl      <= 1'b0;
            r_bd       <= 1'b0;
            r_exc      <= '0;
            r_epc      <= '0;
            r_badvaddr <= '0;
        end else if (w_take) begin
            r_exl <= 1'b1;
            r_bd  <= bd_in;
            r_epc <= w_epc_exc;
            r_exc <= w_int_req ? EXC_W'(0) : exc_code;
            if (w_badv_cap) begin
                r_badvaddr <= bad_vaddr;
            end
        end else begin
            if (w_wr && (wr_addr == ADDR_SR)) begin
                r_im  <= wdata[15:10];
                r_exl <= wdata[1];
                r_ie  <= wdata[0];
            end
            if (w_wr && (wr_addr == ADDR_EPC)) begin
                r_epc <= wdata & WORD_MASK;
            end
            if (eret) begin
                r_exl <= 1'b0;
                r_bd  <= 1'b0;
            end
        end
    end

    // mfc0 read mux
    always_comb begin
        rdata = '0;
        case (rd_addr)
            ADDR_BADVADDR: rdata = r_badvaddr;
            ADDR_COUNT:    rdata = r_count;
            ADDR_COMPARE:  rdata = r_compare;
            ADDR_SR:       rdata = {16'b0, r_im, 8'b0, r_exl, r_ie};
            ADDR_CAUSE:    rdata = {r_bd, 15'b0, r_ip, 3'b0, r_exc, 2'b0};
            ADDR_EPC:      rdata = r_epc;
            ADDR_PRID:     rdata = PRID;
            default:       rdata = '0;
        endcase
    end

endmodule
